// File: rtl/rename_map.sv
// rename_map: register renamer with speculative/retirement RATs, circular free list, ready table and flush recovery.
module rename_map #(
  parameter int NUM_UOPS = 32,
  parameter int XLEN = 32,
  parameter int ARCHFILE_SIZE = 32,
  parameter int PHYSFILE_SIZE = 256,
  parameter int ROB_SIZE = 128,
  localparam int UW = $clog2(NUM_UOPS),
  localparam int AW = $clog2(ARCHFILE_SIZE),
  localparam int PW = $clog2(PHYSFILE_SIZE),
  localparam int RW = $clog2(ROB_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [UW-1:0]   uop_in,
  input  logic            eoi_in,
  input  logic            use_imm_in,
  input  logic            except_in,
  input  logic [AW-1:0]   src1_arch_in,
  input  logic [AW-1:0]   src2_arch_in,
  input  logic [AW-1:0]   dest_arch_in,
  input  logic            dest_wr_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [31:0]     pc_in,
  input  logic            rob_full,
  input  logic [RW-1:0]   rob_entry_in,
  output logic            alloc_rob,
  input  logic            wb_valid,
  input  logic [PW-1:0]   wb_tag,
  input  logic            cmt_valid,
  input  logic            cmt_dest_wr,
  input  logic [AW-1:0]   cmt_dest_arch,
  input  logic [PW-1:0]   cmt_dest_phys,
  input  logic [PW-1:0]   cmt_dest_oldphys,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [UW-1:0]   uop_out,
  output logic            eoi_out,
  output logic            use_imm_out,
  output logic            except_out,
  output logic [XLEN-1:0] imm_out,
  output logic [31:0]     pc_out,
  output logic            op1_rdy_out,
  output logic            op2_rdy_out,
  output logic [PW-1:0]   op1_tag_out,
  output logic [PW-1:0]   op2_tag_out,
  output logic            dest_wr_out,
  output logic [AW-1:0]   dest_arch_out,
  output logic [PW-1:0]   dest_tag_out,
  output logic [PW-1:0]   dest_oldtag_out,
  output logic [RW-1:0]   rob_entry_out
);
  logic [PW-1:0] srat [ARCHFILE_SIZE];
  logic [PW-1:0] rrat [ARCHFILE_SIZE];
  logic [PW-1:0] fl [PHYSFILE_SIZE];
  logic [PHYSFILE_SIZE-1:0] ready;
  logic [PW:0] head, chead, tail, fl_count;
  logic need, fire, cmt_en, op1_rdy, op2_rdy;
  logic [PW-1:0] src1_tag, src2_tag, new_tag, old_tag;

  assign need = dest_wr_in && dest_arch_in != '0;
  assign fl_count = tail - head;
  assign in_ready = !rst && !flush && !rob_full && (!need || fl_count != '0) && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  assign alloc_rob = fire;
  assign cmt_en = cmt_valid && cmt_dest_wr && cmt_dest_arch != '0;
  assign src1_tag = src1_arch_in == '0 ? '0 : srat[src1_arch_in];
  assign src2_tag = src2_arch_in == '0 ? '0 : srat[src2_arch_in];
  assign op1_rdy = src1_arch_in == '0 || ready[src1_tag] || (wb_valid && wb_tag == src1_tag);
  assign op2_rdy = src2_arch_in == '0 || ready[src2_tag] || (wb_valid && wb_tag == src2_tag);
  assign new_tag = need ? fl[head[PW-1:0]] : '0;
  assign old_tag = need ? srat[dest_arch_in] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCHFILE_SIZE; i++) begin
        srat[i] <= PW'(i);
        rrat[i] <= PW'(i);
      end
      for (int i = 0; i < PHYSFILE_SIZE; i++) fl[i] <= PW'(ARCHFILE_SIZE + i);
      head <= '0;
      chead <= '0;
      tail <= (PW+1)'(PHYSFILE_SIZE - ARCHFILE_SIZE);
      ready <= '1;
      out_valid <= 1'b0;
      uop_out <= '0;
      eoi_out <= 1'b0;
      use_imm_out <= 1'b0;
      except_out <= 1'b0;
      imm_out <= '0;
      pc_out <= '0;
      op1_rdy_out <= 1'b0;
      op2_rdy_out <= 1'b0;
      op1_tag_out <= '0;
      op2_tag_out <= '0;
      dest_wr_out <= 1'b0;
      dest_arch_out <= '0;
      dest_tag_out <= '0;
      dest_oldtag_out <= '0;
      rob_entry_out <= '0;
    end else begin
      if (cmt_en) begin
        assert (fl_count != (PW+1)'(PHYSFILE_SIZE));
        rrat[cmt_dest_arch] <= cmt_dest_phys;
        fl[tail[PW-1:0]] <= cmt_dest_oldphys;
        tail <= tail + 1'b1;
        chead <= chead + 1'b1;
      end
      if (flush) begin
        // Recovery sees the retirement state including this cycle's commit
        for (int i = 0; i < ARCHFILE_SIZE; i++)
          srat[i] <= (cmt_en && cmt_dest_arch == AW'(i)) ? cmt_dest_phys : rrat[i];
        head <= chead + {{PW{1'b0}}, cmt_en};
        ready <= '1;
        out_valid <= 1'b0;
      end else begin
        if (wb_valid && wb_tag != '0) ready[wb_tag] <= 1'b1;
        // Later assignment wins: a fresh allocation overrides a same-cycle writeback
        if (fire && need) begin
          srat[dest_arch_in] <= new_tag;
          ready[new_tag] <= 1'b0;
          head <= head + 1'b1;
        end
        if (fire) begin
          out_valid <= 1'b1;
          uop_out <= uop_in;
          eoi_out <= eoi_in;
          use_imm_out <= use_imm_in;
          except_out <= except_in;
          imm_out <= imm_in;
          pc_out <= pc_in;
          op1_rdy_out <= op1_rdy;
          op2_rdy_out <= op2_rdy;
          op1_tag_out <= src1_tag;
          op2_tag_out <= src2_tag;
          dest_wr_out <= need;
          dest_arch_out <= dest_arch_in;
          dest_tag_out <= new_tag;
          dest_oldtag_out <= old_tag;
          rob_entry_out <= rob_entry_in;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule
